// File: rtl/sub16_nibble_serial.sv
// ---------------------------------------------------------------------------
// sub16_nibble_serial
//
// Multi-cycle two's-complement subtractor: diff = a - b - bin (mod 2^WIDTH).
// One SLICE-bit slice is processed per clock, least significant slice first.
// The borrow is held in a register between slices. This is a low-area
// subtract/compare path that sits beside the CLA adder in the ALU.
// Exactly one operation is in flight at a time.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (IDLE and not in reset)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer accepts result
//   diff       out  WIDTH  a - b - bin, mod 2^WIDTH
//   bout       out  1      borrow-out; 1 iff unsigned a < b + bin
//   ovf        out  1      signed overflow
//   zero       out  1      diff == 0
// ---------------------------------------------------------------------------
module sub16_nibble_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;     // borrow between slices; carry = ~borrow
    logic [WIDTH-1:0] a_q, b_q;     // operands captured at accept
    logic [WIDTH-1:0] diff_q;
    logic             nz_q;         // some earlier slice of this result was non-zero
    logic             bout_q, ovf_q, zero_q;

    logic             accept;
    logic             retire;
    logic             last;
    logic [SLICE-1:0] a_sl, b_sl, s;
    logic [SLICE:0]   sum;
    logic             c;

    assign in_ready = (state_q == IDLE) & rst_n;
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;
    assign last      = (cnt_q == LAST);

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

    // Select the current slice of each latched operand. A compare-per-slice
    // mux keeps every part-select constant.
    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned; otherwise a latch is inferred.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (cnt_q == CW'(k)) begin
                a_sl = a_q[k*SLICE +: SLICE];
                b_sl = b_q[k*SLICE +: SLICE];
            end
        end
    end

    // Subtraction as addition: a + ~b + carry, with carry = ~borrow.
    assign sum = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE{1'b0}}, ~borrow_q};
    assign s   = sum[SLICE-1:0];
    assign c   = sum[SLICE];

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last)   state_d = DONE;
            DONE:    if (retire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    // NOTE: every register here is a plain flop, so all of them take the
    // asynchronous reset; a reset mid-operation therefore clears all outputs
    // and discards the in-flight operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            nz_q     <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
            nz_q     <= 1'b0;
        end else if (state_q == RUN) begin
            for (int k = 0; k < NSLICE; k++) begin
                if (cnt_q == CW'(k)) begin
                    diff_q[k*SLICE +: SLICE] <= s;
                end
            end
            borrow_q <= ~c;
            nz_q     <= nz_q | (|s);
            // Counter saturates on the last slice; the state leaves RUN there.
            if (!last) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                bout_q <= ~c;
                ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) & (s[SLICE-1] != a_q[WIDTH-1]);
                zero_q <= ~(nz_q | (|s));
            end
        end
    end

endmodule

// File: tb/tb_sub16_nibble_serial.sv
// ---------------------------------------------------------------------------
// tb_sub16_nibble_serial
//
// Self-checking bench for sub16_nibble_serial. Expected results come from an
// arithmetic reference: {bout,diff} = {1'b0,a} - b - bin, overflow from the
// signed integer range, zero from the difference.
// ---------------------------------------------------------------------------
module tb_sub16_nibble_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        in_ready, out_valid, bout, ovf, zero;
    logic [15:0] diff;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vbin;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    always #5 clk = ~clk;

    sub16_nibble_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Reference model: returns {diff, bout, ovf, zero}.
    function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mbin);
        logic [16:0] r;
        int          sd;
        logic        o;
        r  = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
        sd = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        o  = (sd < -32768) || (sd > 32767);
        return {r[15:0], r[16], o, (r[15:0] == 16'd0)};
    endfunction

    // Hand over one operation and follow it until out_valid, checking latency.
    // Returns #1 after the edge at which out_valid rose (out_ready held low).
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_ready got=%b exp=1", in_ready);
        end
        a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        // Operands may change after the accept edge; in_valid is ignored in RUN.
        for (int cyc = 1; cyc <= 4; cyc++) begin
            in_valid = 1'($urandom);
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
            total++;
            if (out_valid !== (cyc == 4)) begin
                bad++;
                $display("FAIL latency cyc=%0d out_valid got=%b exp=%b", cyc, out_valid, (cyc == 4));
            end
        end
    endtask

    // Accept the result; the block must be back in IDLE right after the edge.
    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL drain {out_valid,in_ready} got=%b exp=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({diff, bout, ovf, zero, out_valid, in_ready} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {diff, bout, ovf, zero, out_valid, in_ready});
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_release {out_valid,in_ready} got=%b exp=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_directed();
        vec_t vecs[4];
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            issue(vecs[i].va, vecs[i].vb, vecs[i].vbin);
            total++;
            if ({diff, bout, ovf, zero} !== {vecs[i].d, vecs[i].bo, vecs[i].ov, vecs[i].z}) begin
                bad++;
                $display("FAIL directed%0d {diff,bout,ovf,zero} got=%h/%b%b%b exp=%h/%b%b%b",
                         i, diff, bout, ovf, zero, vecs[i].d, vecs[i].bo, vecs[i].ov, vecs[i].z);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        issue(16'h1234, 16'h0234, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            total++;
            if ({diff, bout, ovf, zero, out_valid, in_ready} !== {16'h1000, 3'b000, 2'b10}) begin
                bad++;
                $display("FAIL backpressure cyc=%0d diff=%h flags=%b%b%b v=%b r=%b exp diff=1000 flags=000 v=1 r=0",
                         i, diff, bout, ovf, zero, out_valid, in_ready);
            end
        end
        drain();
        @(posedge clk); #1;
        total++;
        if (diff !== 16'h1000) begin
            bad++;
            $display("FAIL idle_hold diff got=%h exp=1000", diff);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        a = 16'hFFFF; b = 16'h0000; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Two RUN edges: slices 0 and 1 written, counter now 2.
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (diff[7:0] !== 8'hFF) begin
            bad++;
            $display("FAIL midrun_partial diff got=%h exp=xxFF", diff);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({diff, bout, ovf, zero, out_valid, in_ready} !== 21'd0) begin
            bad++;
            $display("FAIL midrun_reset got=%h exp=0", {diff, bout, ovf, zero, out_valid, in_ready});
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL midrun_release {out_valid,in_ready} got=%b exp=01", {out_valid, in_ready});
        end
        issue(16'h0010, 16'h0001, 1'b0);
        total++;
        if ({diff, bout} !== {16'h000F, 1'b0}) begin
            bad++;
            $display("FAIL midrun_after diff=%h bout=%b exp diff=000F bout=0", diff, bout);
        end
        drain();
    endtask

    task automatic test_random();
        logic [15:0] ra, rb;
        logic        rbin;
        logic [18:0] exp_v;
        int          k;
        for (int i = 0; i < 3000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            // Bias some vectors towards equal/adjacent operands for zero and borrow edges.
            if (i % 8 == 0) rb = ra - 16'(rbin);
            if (i % 8 == 1) rb = ra;
            exp_v = model(ra, rb, rbin);
            issue(ra, rb, rbin);
            total++;
            if ({diff, bout, ovf, zero} !== exp_v) begin
                bad++;
                $display("FAIL random%0d a=%h b=%h bin=%b got=%h/%b%b%b exp=%h/%b%b%b", i, ra, rb, rbin,
                         diff, bout, ovf, zero, exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
            end
            k = $urandom_range(0, 3);
            repeat (k) begin
                in_valid = 1'($urandom);
                @(posedge clk); #1;
            end
            total++;
            if ({diff, bout, ovf, zero, out_valid} !== {exp_v, 1'b1}) begin
                bad++;
                $display("FAIL random_stall%0d got=%h/%b%b%b v=%b exp=%h", i, diff, bout, ovf, zero,
                         out_valid, exp_v);
            end
            drain();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
